// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - debounces a vector of asynchronous switch inputs
// Synchronizes sw_raw, requires SETTLE_CYCLES of no change before accepting it.
module gpio_in_debounce #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic [WIDTH-1:0] edge_clr,
  output logic [WIDTH-1:0] sw_stable,
  output logic             changed,
  output logic [WIDTH-1:0] rise_flags,
  output logic             settling
);

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic [19:0] CNT_LAST = 20'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] cand_d;
  logic [19:0]      cnt;
  logic [19:0]      cnt_d;
  logic             commit;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cand  <= cand_d;
      cnt   <= cnt_d;
    end
  end

  // Any change of sync2 during SETTLE restarts the full window; cnt saturates at CNT_LAST.
  always_comb begin
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    commit  = 1'b0;
    case (state)
      STABLE: begin
        cnt_d = '0;
        if (sync2 != sw_stable) begin
          cand_d  = sync2;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2 != cand) begin
          cand_d = sync2;
          cnt_d  = '0;
        end else if (cnt == CNT_LAST) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = STABLE;
        end else begin
          cnt_d = cnt + 20'd1;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stable_d = commit ? cand : sw_stable;
  assign rise_set = stable_d & ~sw_stable;

  // Set has priority over edge_clr so a rise coinciding with a clear is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_stable  <= '0;
      changed    <= 1'b0;
      rise_flags <= '0;
      settling   <= 1'b0;
    end else begin
      sw_stable  <= stable_d;
      changed    <= commit && (cand != sw_stable);
      rise_flags <= (rise_flags & ~edge_clr) | rise_set;
      settling   <= (state_d == SETTLE);
    end
  end

endmodule

// File: doc/gpio_in_debounce.md
GPIO_IN_DEBOUNCE -- requirements
Module: gpio_in_debounce

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter WIDTH SHALL default to 32 and set the number of input bits debounced.
REQ-003 Parameter SETTLE_CYCLES SHALL default to 50000 and set the cycles an input vector must hold unchanged before acceptance; legal range 2..2^20.
REQ-004 Port clk SHALL be an input, 1 bit: the system clock shared with the cpu.
REQ-005 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 Port sw_raw SHALL be an input, WIDTH bits: asynchronous board switches/keys.
REQ-007 Port edge_clr SHALL be an input, WIDTH bits: per-bit clear of sticky edge flags, synchronous.
REQ-008 Port sw_stable SHALL be an output, WIDTH bits: the debounced vector, driven to cpu gpio_in.
REQ-009 Port changed SHALL be an output, 1 bit: a one-cycle pulse when sw_stable updates to a new value.
REQ-010 Port rise_flags SHALL be an output, WIDTH bits: sticky per-bit 0->1 transitions of sw_stable.
REQ-011 Port settling SHALL be an output, 1 bit: high while the FSM is in SETTLE.

Function
REQ-012 Input sync: sw_raw SHALL pass a 2-flop synchronizer (sync1, sync2) per bit; only sync2 feeds downstream logic.
REQ-013 The FSM SHALL have two states, STABLE and SETTLE; registers are cand[WIDTH] and cnt[20].
REQ-014 In STABLE with sync2 == sw_stable, the FSM SHALL hold: cnt = 0, no output change.
REQ-015 In STABLE with sync2 != sw_stable, the FSM SHALL load cand <= sync2 and cnt <= 0, then go to SETTLE.
REQ-016 In SETTLE with sync2 != cand, the FSM SHALL load cand <= sync2 and cnt <= 0, and remain in SETTLE (restart).
REQ-017 In SETTLE with sync2 == cand and cnt < SETTLE_CYCLES-1, the FSM SHALL increment cnt; cnt SHALL never wrap.
REQ-018 In SETTLE with sync2 == cand and cnt == SETTLE_CYCLES-1, the FSM SHALL set sw_stable <= cand and go to STABLE; changed SHALL pulse high in the following cycle only if cand != prior sw_stable.
REQ-019 A bounce back to the original value followed by a full settle SHALL return to STABLE with sw_stable unchanged and no changed pulse.
REQ-020 Latency: a clean input step SHALL appear on sw_stable exactly 2 (sync) + 1 (detect) + SETTLE_CYCLES cycles after the first clk edge that samples it.
REQ-021 rise_flags[i] SHALL set on the cycle sw_stable[i] goes 0->1 and hold until edge_clr[i] is high.
REQ-022 If set and clear of rise_flags[i] coincide in one cycle, set SHALL win.
REQ-023 settling SHALL equal (state == SETTLE), registered with the state.
REQ-024 All outputs SHALL be registered; there SHALL be no combinational path from sw_raw to any output.

Reset
REQ-025 rst_n low SHALL immediately force sync1, sync2, cand, sw_stable, and rise_flags to 0, cnt to 0, changed to 0, and state to STABLE.
REQ-026 Reset asserted mid-SETTLE SHALL abandon the candidate; after release, the block SHALL re-evaluate from sync2 with a full SETTLE_CYCLES window.
REQ-027 Deassertion SHALL be synchronized externally; the block SHALL require no internal reset sequencing.

Verification (SETTLE_CYCLES=8, WIDTH=32)
REQ-028 Reset, then hold sw_raw=0 for 20 cycles -> sw_stable=0, changed never high, settling low.
REQ-029 Step sw_raw 0 -> 0x00000005 and hold -> sw_stable=0x00000005 exactly 11 cycles later; changed high 1 cycle; rise_flags=0x00000005.
REQ-030 Toggle sw_raw bit0 every 3 cycles for 30 cycles, then hold 1 -> no update during toggling; settling high throughout; single update after 8 stable cycles.
REQ-031 Glitch sw_raw 0x5 -> 0x7 for 4 cycles, then back to 0x5 -> sw_stable stays 0x5, changed never pulses, settling returns low.
REQ-032 With rise_flags=0x5, pulse edge_clr=0x1 on the same cycle bit0 re-rises -> rise_flags bit0 stays 1; separate edge_clr=0x4 -> rise_flags=0x1.
REQ-033 Assert rst_n low at cnt=5 in SETTLE -> all outputs 0 asynchronously; after release with sw_raw held, update occurs 11 cycles later.
